// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency/period meter: FSM encoding and
// default measurement parameters.
package freq_meter_pkg;

    localparam int unsigned GATE_CYCLES_DEF = 48000;
    localparam int unsigned CNT_W_DEF       = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a third
// register, producing a one-cycle pulse on each synchronized rising edge.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = d_async;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter (frequency) plus free-running edge-to-edge runner (period)
// for an asynchronous input; results are registered and pulsed by meas_valid.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] freq_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             overflow,
    output logic             sig_lost
);

    localparam int unsigned      GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic rise;

    state_e           state_q, state_d;
    logic [GW-1:0]    gate_q, gate_d;
    logic [CNT_W-1:0] edge_q, edge_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             ovf_q, ovf_d;
    logic             lost_q, lost_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] runner_q, runner_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             primed_q, primed_d;

    sync_edge u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_async (sig_in),
        .rise    (rise)
    );

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        edge_d  = edge_q;
        sat_d   = sat_q;
        freq_d  = freq_q;
        ovf_d   = ovf_q;
        lost_d  = lost_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = GATE;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end
            end
            GATE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    gate_d = gate_q + GW'(1);
                    if (rise) begin
                        if (edge_q == CNT_MAX) begin
                            sat_d = 1'b1;
                        end else begin
                            edge_d = edge_q + CNT_W'(1);
                        end
                    end
                    if (gate_q == GATE_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    // Publish the closed window while the DONE-cycle edge seeds the next one.
                    valid_d = 1'b1;
                    freq_d  = edge_q;
                    ovf_d   = sat_q;
                    lost_d  = (edge_q == '0);
                    state_d = GATE;
                    gate_d  = '0;
                    edge_d  = rise ? CNT_W'(1) : '0;
                    sat_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        runner_d = (runner_q == CNT_MAX) ? runner_q : runner_q + CNT_W'(1);
        period_d = period_q;
        primed_d = primed_q;
        if (rise) begin
            if (primed_q && state_q != IDLE) begin
                period_d = runner_q;
            end
            runner_d = CNT_W'(1);
            primed_d = 1'b1;
        end
        // Idle drops the reference edge so a stale interval is never reported.
        if (state_q == IDLE) begin
            primed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gate_q   <= '0;
            edge_q   <= '0;
            sat_q    <= 1'b0;
            freq_q   <= '0;
            ovf_q    <= 1'b0;
            lost_q   <= 1'b0;
            valid_q  <= 1'b0;
            runner_q <= '0;
            period_q <= '0;
            primed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gate_q   <= gate_d;
            edge_q   <= edge_d;
            sat_q    <= sat_d;
            freq_q   <= freq_d;
            ovf_q    <= ovf_d;
            lost_q   <= lost_d;
            valid_q  <= valid_d;
            runner_q <= runner_d;
            period_q <= period_d;
            primed_q <= primed_d;
        end
    end

    assign freq_cnt   = freq_q;
    assign period_cnt = period_q;
    assign meas_valid = valid_q;
    assign overflow   = ovf_q;
    assign sig_lost   = lost_q;

endmodule

// File: tb/tb_freq_meter.sv
// Randomized bench for freq_meter: a cycle-level behavioural model derived from
// window arithmetic predicts every output on every clock.
module tb_freq_meter;

    localparam int unsigned GC     = 960;
    localparam int unsigned CW     = 8;
    localparam int unsigned MAXV   = (1 << CW) - 1;
    localparam int unsigned WSPAN  = GC + 1;

    logic          clk;
    logic          rst_n;
    logic          sig_in;
    logic          enable;
    logic [CW-1:0] freq_cnt;
    logic [CW-1:0] period_cnt;
    logic          meas_valid;
    logic          overflow;
    logic          sig_lost;

    int n_tests;
    int n_fail;

    freq_meter #(
        .GATE_CYCLES (GC),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .enable     (enable),
        .freq_cnt   (freq_cnt),
        .period_cnt (period_cnt),
        .meas_valid (meas_valid),
        .overflow   (overflow),
        .sig_lost   (sig_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference model state.
    bit      hist[$];
    bit      en_prev;
    longint  cyc;
    longint  run_k;
    longint  cnt;
    bit      primed;
    longint  last_edge;
    int      exp_valid, exp_freq, exp_ovf, exp_lost, exp_period;

    function automatic int satv(input longint v);
        return (v > MAXV) ? MAXV : int'(v);
    endfunction

    always @(posedge clk) begin
        bit ev;
        if (!rst_n) begin
            hist       = '{1'b0, 1'b0, 1'b0, 1'b0};
            en_prev    = 1'b0;
            run_k      = 0;
            cnt        = 0;
            primed     = 1'b0;
            last_edge  = 0;
            exp_valid  = 0;
            exp_freq   = 0;
            exp_ovf    = 0;
            exp_lost   = 0;
            exp_period = 0;
            cyc        = 0;
        end else begin
            // An input rise shows up as a counted edge three samples later.
            hist.push_front(sig_in);
            void'(hist.pop_back());
            ev = hist[2] && !hist[3];
            exp_valid = 0;
            if (!en_prev) begin
                primed = 1'b0;
                if (enable) begin
                    run_k = 0;
                    cnt   = 0;
                end
            end else begin
                if (ev) begin
                    if (primed) exp_period = satv(cyc - last_edge);
                    last_edge = cyc;
                    primed    = 1'b1;
                end
                run_k++;
                if (enable) begin
                    if (run_k % WSPAN == 0) begin
                        exp_valid = 1;
                        exp_freq  = satv(cnt);
                        exp_ovf   = (cnt > MAXV) ? 1 : 0;
                        exp_lost  = (cnt == 0) ? 1 : 0;
                        cnt       = ev ? 1 : 0;
                    end else begin
                        cnt += ev ? 1 : 0;
                    end
                end
            end
            en_prev = enable;
            cyc++;
        end
    end

    always @(posedge clk) begin
        #2;
        chk("meas_valid", meas_valid, exp_valid);
        chk("freq_cnt",   freq_cnt,   exp_freq);
        chk("overflow",   overflow,   exp_ovf);
        chk("sig_lost",   sig_lost,   exp_lost);
        chk("period_cnt", period_cnt, exp_period);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic square(input int per, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sig_in = ((i % per) < hi);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_freq",   freq_cnt,   0);
        chk("rst_period", period_cnt, 0);
        chk("rst_valid",  meas_valid, 0);
        chk("rst_ovf",    overflow,   0);
        chk("rst_lost",   sig_lost,   0);
        cycles(3);
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        enable  = 1'b0;
        sig_in  = 1'b0;
        cycles(4);
        rst_n = 1'b1;
        cycles(3);

        // Periodic input: 96-cycle square wave.
        enable = 1'b1;
        square(96, 48, 4 * WSPAN);

        // Static input from a fresh reset: low then high.
        do_reset();
        sig_in = 1'b0;
        enable = 1'b1;
        cycles(3 * WSPAN + 2);
        sig_in = 1'b1;
        cycles(3 * WSPAN);

        // Saturation: edge rate above the counter range, then silence.
        square(3, 2, 2 * WSPAN);
        sig_in = 1'b0;
        cycles(2 * WSPAN);

        // Enable drop mid-window.
        enable = 1'b0;
        cycles(5);
        enable = 1'b1;
        square(40, 20, 500);
        enable = 1'b0;
        cycles(20);
        enable = 1'b1;
        square(40, 20, WSPAN + 200);

        // Edges every other cycle land on every window boundary phase.
        square(2, 1, 3 * WSPAN);

        // Reset mid-window.
        square(50, 25, 300);
        do_reset();
        square(50, 25, WSPAN + 100);

        // Random segments with occasional enable drops.
        for (int s = 0; s < 8; s++) begin
            int per, hi, len, drop_at, drop_len;
            per      = $urandom_range(2, 60);
            hi       = $urandom_range(1, per - 1);
            len      = $urandom_range(400, 1500);
            drop_at  = ($urandom_range(0, 2) == 0) ? $urandom_range(10, len - 50) : -1;
            drop_len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                sig_in = ((i % per) < hi);
                if (i == drop_at)            enable = 1'b0;
                if (i == drop_at + drop_len) enable = 1'b1;
            end
            enable = 1'b1;
        end

        cycles(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
